// File: rtl/me_search_column_loader.sv
// Write-side filler for the 3-slot search-window column buffer: turns a
// column-major pixel stream into buffer writes and tracks slot occupancy.
module me_search_column_loader #(
    parameter int unsigned COL_H     = 47,
    parameter int unsigned NUM_SLOTS = 3,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        num_cols,
    input  logic [7:0]        pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              col_release,
    output logic              search_write,
    output logic [ADDR_W-1:0] search_write_addr,
    output logic [7:0]        search_write_data,
    output logic              col_done,
    output logic [1:0]        col_slot,
    output logic [1:0]        filled,
    output logic              busy,
    output logic              strip_done
);

    localparam int unsigned ROW_W  = $clog2(COL_H);
    localparam int unsigned SLOT_W = 2;
    localparam int unsigned FILL_W = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PIX_W  = 8;

    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(COL_H - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [FILL_W-1:0] FULL_CNT  = FILL_W'(NUM_SLOTS);
    localparam logic [FILL_W-1:0] FULL_M1   = FILL_W'(NUM_SLOTS - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LOAD      = 2'd1;
    localparam logic [1:0] S_WAIT_FREE = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [ROW_W-1:0]  row, row_nxt;
    logic [SLOT_W-1:0] slot, slot_nxt;
    logic [CNT_W-1:0]  remaining, remaining_nxt;
    logic [FILL_W-1:0] filled_nxt;
    logic              pix_ready_nxt;
    logic              write_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [PIX_W-1:0]  data_nxt;
    logic              col_done_nxt;
    logic [SLOT_W-1:0] col_slot_nxt;
    logic              strip_done_nxt;
    logic              busy_nxt;
    logic              accept;
    logic              rel_eff;

    // Next-state and registered-output decode
    always_comb begin
        state_nxt      = state;
        row_nxt        = row;
        slot_nxt       = slot;
        remaining_nxt  = remaining;
        write_nxt      = 1'b0;
        addr_nxt       = search_write_addr;
        data_nxt       = search_write_data;
        col_done_nxt   = 1'b0;
        col_slot_nxt   = col_slot;
        strip_done_nxt = 1'b0;

        accept     = pix_valid && pix_ready;
        // A release on an empty buffer only counts when it cancels a completion
        rel_eff    = col_release && ((filled != '0) || col_done);
        filled_nxt = filled + FILL_W'(col_done) - FILL_W'(rel_eff);

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (num_cols == '0) begin
                        strip_done_nxt = 1'b1;
                    end else begin
                        remaining_nxt = num_cols;
                        state_nxt     = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    write_nxt = 1'b1;
                    addr_nxt  = ADDR_W'(slot) * ADDR_W'(COL_H) + ADDR_W'(row);
                    data_nxt  = pix_data;
                    if (row == LAST_ROW) begin
                        row_nxt       = '0;
                        slot_nxt      = (slot == LAST_SLOT) ? '0 : slot + SLOT_W'(1);
                        col_done_nxt  = 1'b1;
                        col_slot_nxt  = slot;
                        remaining_nxt = remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state_nxt      = S_IDLE;
                            strip_done_nxt = 1'b1;
                        end else if (filled_nxt >= FULL_M1) begin
                            // This column's completion will fill the last free slot
                            state_nxt = S_WAIT_FREE;
                        end
                    end else begin
                        row_nxt = row + ROW_W'(1);
                    end
                end
            end
            S_WAIT_FREE: begin
                // While a completion is still being counted, look through it
                if (col_done ? (filled_nxt < FULL_CNT) : (filled < FULL_CNT)) begin
                    state_nxt = S_LOAD;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        pix_ready_nxt = (state_nxt == S_LOAD) && (filled_nxt < FULL_CNT);
        busy_nxt      = (state_nxt != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            row               <= '0;
            slot              <= '0;
            remaining         <= '0;
            filled            <= '0;
            pix_ready         <= 1'b0;
            search_write      <= 1'b0;
            search_write_addr <= '0;
            search_write_data <= '0;
            col_done          <= 1'b0;
            col_slot          <= '0;
            strip_done        <= 1'b0;
            busy              <= 1'b0;
        end else begin
            state             <= state_nxt;
            row               <= row_nxt;
            slot              <= slot_nxt;
            remaining         <= remaining_nxt;
            filled            <= filled_nxt;
            pix_ready         <= pix_ready_nxt;
            search_write      <= write_nxt;
            search_write_addr <= addr_nxt;
            search_write_data <= data_nxt;
            col_done          <= col_done_nxt;
            col_slot          <= col_slot_nxt;
            strip_done        <= strip_done_nxt;
            busy              <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_me_search_column_loader.sv
// Directed bench for me_search_column_loader: strips, full-buffer stall,
// release timing, mid-column reset and zero-column strips.
module tb_me_search_column_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] num_cols;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic       col_release;
    logic       search_write;
    logic [7:0] search_write_addr;
    logic [7:0] search_write_data;
    logic       col_done;
    logic [1:0] col_slot;
    logic [1:0] filled;
    logic       busy;
    logic       strip_done;

    int         vectors     = 0;
    int         miscompares = 0;
    int         exp_addr    = 0;
    logic [7:0] exp_data    = 8'h00;
    int         cyc_used;

    always #5 clk = ~clk;

    me_search_column_loader dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .num_cols          (num_cols),
        .pix_data          (pix_data),
        .pix_valid         (pix_valid),
        .pix_ready         (pix_ready),
        .col_release       (col_release),
        .search_write      (search_write),
        .search_write_addr (search_write_addr),
        .search_write_data (search_write_data),
        .col_done          (col_done),
        .col_slot          (col_slot),
        .filled            (filled),
        .busy              (busy),
        .strip_done        (strip_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer npix pixels; every write must follow its accept by one cycle at the next address
    task automatic stream(input int npix, input bit rnd, output int cycles);
        int got;
        bit acc;
        got    = 0;
        cycles = 0;
        while (got < npix && cycles < 1000) begin
            pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_data  = exp_data;
            acc       = pix_valid && pix_ready;
            tick();
            cycles++;
            check("write_strobe", 32'(search_write), 32'(acc));
            check("col_done", 32'(col_done), 32'(acc && (exp_addr % 47 == 46)));
            if (acc) begin
                check("write_addr", 32'(search_write_addr), 32'(exp_addr));
                check("write_data", 32'(search_write_data), 32'(exp_data));
                if (exp_addr % 47 == 46)
                    check("col_slot", 32'(col_slot), 32'(exp_addr / 47));
                exp_addr = (exp_addr == 140) ? 0 : exp_addr + 1;
                exp_data = exp_data + 8'd1;
                got++;
            end
        end
        pix_valid = 1'b0;
        if (got < npix) check("stream_timeout", 32'(got), 32'(npix));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; num_cols = 8'd0; pix_data = 8'd0;
        pix_valid = 1'b0; col_release = 1'b0;
        tick(); tick();
        check("rst_write", 32'(search_write), 32'd0);
        check("rst_addr", 32'(search_write_addr), 32'd0);
        check("rst_data", 32'(search_write_data), 32'd0);
        check("rst_col_done", 32'(col_done), 32'd0);
        check("rst_col_slot", 32'(col_slot), 32'd0);
        check("rst_filled", 32'(filled), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strip_done", 32'(strip_done), 32'd0);
        check("rst_ready", 32'(pix_ready), 32'd0);
        rst = 1'b0;
        tick();

        // One column, pixels 0x00..0x2E into addresses 0..46
        start = 1'b1; num_cols = 8'd1; tick(); start = 1'b0;
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ready", 32'(pix_ready), 32'd1);
        stream(47, 1'b0, cyc_used);
        check("t1_no_bubble", 32'(cyc_used), 32'd47);
        check("t1_strip_done", 32'(strip_done), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_ready_end", 32'(pix_ready), 32'd0);
        tick();
        check("t1_filled", 32'(filled), 32'd1);
        check("t1_strip_pulse", 32'(strip_done), 32'd0);
        check("t1_write_idle", 32'(search_write), 32'd0);
        col_release = 1'b1; tick(); col_release = 1'b0;
        check("rel_filled", 32'(filled), 32'd0);
        col_release = 1'b1; tick(); col_release = 1'b0;
        check("rel_empty", 32'(filled), 32'd0);

        // Four columns from a clean state: stall on a full buffer
        rst = 1'b1; tick(); rst = 1'b0;
        exp_addr = 0; exp_data = 8'h40;
        start = 1'b1; num_cols = 8'd4; tick(); start = 1'b0;
        stream(141, 1'b0, cyc_used);
        check("t2_no_bubble", 32'(cyc_used), 32'd141);
        check("t2_ready_full", 32'(pix_ready), 32'd0);
        check("t2_filled_pre", 32'(filled), 32'd2);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_strip_early", 32'(strip_done), 32'd0);
        start = 1'b1; num_cols = 8'd0; tick(); start = 1'b0;
        check("t2_filled_full", 32'(filled), 32'd3);
        check("t2_start_ignored", 32'(strip_done), 32'd0);
        tick(); tick();
        check("t2_stall_ready", 32'(pix_ready), 32'd0);
        check("t2_stall_busy", 32'(busy), 32'd1);
        check("t2_stall_write", 32'(search_write), 32'd0);
        col_release = 1'b1; tick(); col_release = 1'b0;
        check("t2_rel_c1_ready", 32'(pix_ready), 32'd0);
        check("t2_rel_c1_filled", 32'(filled), 32'd2);
        tick();
        check("t2_rel_c2_ready", 32'(pix_ready), 32'd1);
        stream(47, 1'b0, cyc_used);
        check("t2_col4_no_bubble", 32'(cyc_used), 32'd47);
        check("t2_strip_done", 32'(strip_done), 32'd1);
        check("t2_filled_end", 32'(filled), 32'd2);
        tick();
        check("t2_filled_after", 32'(filled), 32'd3);

        // Release coincident with col_done at filled=2
        col_release = 1'b1; tick(); col_release = 1'b0;
        check("t3_filled_start", 32'(filled), 32'd2);
        start = 1'b1; num_cols = 8'd2; tick(); start = 1'b0;
        check("t3_ready", 32'(pix_ready), 32'd1);
        stream(47, 1'b0, cyc_used);
        check("t3_filled_done", 32'(filled), 32'd2);
        col_release = 1'b1; tick(); col_release = 1'b0;
        check("t3_filled_same", 32'(filled), 32'd2);
        check("t3_ready_resume", 32'(pix_ready), 32'd1);
        check("t3_busy", 32'(busy), 32'd1);

        // Random valid gaps on the final column of the strip
        stream(47, 1'b1, cyc_used);
        check("t4_strip_done", 32'(strip_done), 32'd1);
        check("t4_filled", 32'(filled), 32'd2);
        tick();
        check("t4_filled_after", 32'(filled), 32'd3);

        // Reset at row 20 of a column, then restart from address 0
        rst = 1'b1; tick(); rst = 1'b0;
        exp_addr = 0; exp_data = 8'h80;
        start = 1'b1; num_cols = 8'd2; tick(); start = 1'b0;
        stream(21, 1'b0, cyc_used);
        pix_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; pix_valid = 1'b0;
        check("t5_write", 32'(search_write), 32'd0);
        check("t5_addr", 32'(search_write_addr), 32'd0);
        check("t5_data", 32'(search_write_data), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ready", 32'(pix_ready), 32'd0);
        check("t5_filled", 32'(filled), 32'd0);
        check("t5_col_done", 32'(col_done), 32'd0);
        exp_addr = 0;
        start = 1'b1; num_cols = 8'd1; tick(); start = 1'b0;
        stream(47, 1'b0, cyc_used);
        check("t5_strip_done", 32'(strip_done), 32'd1);
        tick();
        check("t5_filled_after", 32'(filled), 32'd1);

        // Zero-column strip and release on an empty buffer
        col_release = 1'b1; tick(); col_release = 1'b0;
        check("t6_filled_clear", 32'(filled), 32'd0);
        start = 1'b1; num_cols = 8'd0; tick(); start = 1'b0;
        check("t6_strip_done", 32'(strip_done), 32'd1);
        check("t6_write", 32'(search_write), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_ready", 32'(pix_ready), 32'd0);
        tick();
        check("t6_strip_pulse", 32'(strip_done), 32'd0);
        col_release = 1'b1; tick(); col_release = 1'b0;
        check("t6_empty_release", 32'(filled), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/me_search_column_loader.md
Name: me_search_column_loader

Overview:
- Write-side filler for the 3-column search-window register file in the block-matching motion-estimation datapath (141 entries = 3 column slots x 47 rows).
- Accepts a column-major pixel stream over a valid/ready handshake and drives the buffer's write port (write strobe, write address, write data).
- Slots are used round-robin: 0, 1, 2, 0, ...
- Tracks filled versus released slots so the search engine can consume one column while the next loads, and never overwrites a column still in use.

Parameters:
- COL_H, 47, pixels per column (rows per slot).
- NUM_SLOTS, 3, column slots in the buffer.
- ADDR_W, 8, width of the buffer write address.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins loading a strip; ignored unless in IDLE.
- num_cols  in  8  columns to load for this strip; sampled on start; 0 means the strip completes immediately.
- pix_data  in  8  incoming pixel.
- pix_valid  in  1  pix_data is valid.
- pix_ready  out  1  loader accepts a pixel this cycle.
- col_release  in  1  one-cycle pulse from the consumer freeing the oldest filled slot.
- search_write  out  1  write strobe to the buffer.
- search_write_addr  out  8  buffer write address = slot*COL_H + row.
- search_write_data  out  8  buffer write data.
- col_done  out  1  one-cycle pulse coincident with the write strobe of a column's last pixel.
- col_slot  out  2  slot index of the column flagged by col_done.
- filled  out  2  slots currently filled and not yet released (0..3).
- busy  out  1  high in LOAD and WAIT_FREE.
- strip_done  out  1  one-cycle pulse when the last column of the strip is written (or on the start of a zero-column strip).

Behaviour:
- Reset values: all outputs 0; state IDLE; write slot 0; row 0; columns remaining 0; filled 0.
- Reset mid-operation aborts the strip. Any buffer write strobe already presented completes; nothing after it.
- Handshake:
  - A pixel is accepted when pix_valid && pix_ready on a rising edge.
  - pix_ready = (state==LOAD) && (filled<NUM_SLOTS). It is a combinational function of registers only, with no dependence on pix_valid.
  - pix_data may change freely while pix_ready is low.
- Write latency: one cycle.
  - The cycle after acceptance: search_write=1, search_write_addr = slot*COL_H + row, search_write_data = accepted pixel.
  - search_write is low on every cycle with no accepted pixel in the previous cycle.
- Row/slot counters:
  - row increments on each accept.
  - At row==COL_H-1 the accept wraps row to 0 and advances slot: 2 wraps to 0.
  - Slot bases are 0, 47, 94. Maximum address is 140. Addresses 141..255 are never driven.
- col_done/col_slot:
  - Pulse in the same cycle as the write strobe of row COL_H-1.
  - col_slot holds the slot just completed.
- filled:
  - +1 on col_done, -1 on col_release.
  - Both in the same cycle leaves it unchanged.
  - col_release while filled==0 (without a simultaneous col_done) is ignored.
  - Saturates at NUM_SLOTS by construction, because pix_ready is low when full.
- FSM:
  - IDLE: on start with num_cols==0, pulse strip_done next cycle and stay in IDLE. On start with num_cols>0, load the remaining count and go to LOAD.
  - LOAD: accept pixels. On the accept that completes a column, decrement remaining. If remaining becomes 0, go to IDLE; strip_done pulses together with that column's col_done. Otherwise, if filled will become NUM_SLOTS, go to WAIT_FREE.
  - WAIT_FREE: pix_ready=0. When filled drops below NUM_SLOTS, return to LOAD the next cycle.
- Slot pointer and filled are not cleared between strips; only rst clears them. The consumer must release leftover columns.
- start while busy is ignored.
- Back-to-back pixels every cycle sustain one write per cycle with no bubbles, except stalls caused by a full buffer.

Test Plan:
- Reset, then start with num_cols=1 and 47 pixels 0x00..0x2E streamed every cycle -> writes to addresses 0..46 with matching data one cycle after each accept; col_done with col_slot=0 on address 46; strip_done in the same cycle; filled=1.
- start with num_cols=4, no releases, continuous valid -> slots 0,1,2 fill (last addresses 46, 93, 140); filled=3; pix_ready low in WAIT_FREE. A col_release pulse -> pix_ready high 2 cycles later; 4th column writes addresses 0..46 (slot 0).
- Simultaneous col_release and col_done with filled=2 -> filled stays 2, no stall.
- pix_valid toggled 1/0 randomly -> write strobes exactly mirror accepts; no duplicate or skipped addresses.
- rst asserted mid-column at row 20 -> next cycle all outputs 0. A new start then writes from address 0 again.
- start with num_cols=0 -> strip_done pulse next cycle, no writes. col_release with filled=0 -> filled remains 0.
